// File: rtl/core_ctrl_if.sv
// Host/core-facing bundle of core_ctrl: start handshake, layer configuration, OFIFO status in;
// 34-bit core instruction word and layer status out.
interface core_ctrl_if #(
  parameter int addr_w = 11,
  parameter int len_w  = 11,
  parameter int tile_w = 4
);
  localparam int inst_w = 2 * addr_w + 12;

  logic              start;
  logic [addr_w-1:0] cfg_w_base;
  logic [addr_w-1:0] cfg_x_base;
  logic [addr_w-1:0] cfg_p_base;
  logic [len_w-1:0]  cfg_nij;
  logic [tile_w-1:0] cfg_tiles;
  logic              cfg_acc;
  logic              ofifo_valid;
  logic [inst_w-1:0] inst;
  logic              busy;
  logic              done;

  modport master (
    output start, cfg_w_base, cfg_x_base, cfg_p_base, cfg_nij, cfg_tiles, cfg_acc, ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, cfg_w_base, cfg_x_base, cfg_p_base, cfg_nij, cfg_tiles, cfg_acc, ofifo_valid,
    output inst, busy, done
  );
endinterface

// File: rtl/core_ctrl.sv
// Weight-stationary layer sequencer: per tile fetch/load weights, fetch/execute activations, drain OFIFO to pmem.
// inst is registered one cycle behind the FSM state except ofifo_rd, which follows ofifo_valid so OREAD stalls instantly.
module core_ctrl #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int len_w  = 11,
  parameter int tile_w = 4,
  parameter int FLUSH  = 8
) (
  input logic       clk,
  input logic       reset,
  core_ctrl_if.slave bus
);

  typedef struct packed {
    logic              acc;
    logic              cen_p;
    logic              wen_p;
    logic [addr_w-1:0] a_p;
    logic              cen_x;
    logic              wen_x;
    logic [addr_w-1:0] a_x;
    logic              ofifo_rd;
    logic              ififo_wr;
    logic              ififo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_t;

  typedef enum logic [3:0] {
    IDLE, WL0, WLOAD, WGAP, XL0, EXEC, DRAIN, OREAD, NEXT, DONE
  } state_t;

  localparam inst_t IDLE_WORD = '{cen_p: 1'b1, wen_p: 1'b1, cen_x: 1'b1, wen_x: 1'b1, default: '0};
  localparam logic [len_w-1:0]  COL_K    = len_w'(col);
  localparam logic [len_w-1:0]  COL_LAST = len_w'(col - 1);
  localparam logic [len_w-1:0]  GAP_LAST = len_w'(FLUSH - 1);
  localparam logic [addr_w-1:0] COL_A    = addr_w'(col);

  if (row < 1 || col < 1 || FLUSH < 1) begin : g_bad_param
    $error("core_ctrl: row, col and FLUSH must be at least 1");
  end

  state_t            state;
  logic [len_w-1:0]  k;
  logic [len_w-1:0]  o;
  logic [len_w-1:0]  nij;
  logic [tile_w-1:0] t;
  logic [tile_w-1:0] tiles;
  logic [addr_w-1:0] w_row;
  logic [addr_w-1:0] x_base;
  logic [addr_w-1:0] p_base;
  logic              acc_en;
  logic              busy_q;
  logic              done_q;
  logic              rd;
  inst_t             inst_d;
  inst_t             inst_q;
  inst_t             inst_o;

  always_comb rd = (state == OREAD) && bus.ofifo_valid && (o != nij);

  // Word for the next cycle; the xmem read and the matching l0_wr one cycle later come from the same counter.
  always_comb begin
    inst_d = IDLE_WORD;
    case (state)
      WL0: begin
        if (k < COL_K) begin
          inst_d.cen_x = 1'b0;
          inst_d.a_x   = w_row + addr_w'(k);
        end
        inst_d.l0_wr = (k != '0);
      end
      WLOAD: begin
        inst_d.l0_rd = 1'b1;
        inst_d.load  = 1'b1;
      end
      XL0: begin
        if (k < nij) begin
          inst_d.cen_x = 1'b0;
          inst_d.a_x   = x_base + addr_w'(k);
        end
        inst_d.l0_wr = (k != '0);
      end
      EXEC: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
      end
      default: ;
    endcase
    if (rd) begin
      inst_d.cen_p = 1'b0;
      inst_d.wen_p = 1'b0;
      inst_d.a_p   = p_base + addr_w'(o);
      inst_d.acc   = acc_en && (t != '0);
    end
  end

  always_comb begin
    inst_o          = inst_q;
    inst_o.ofifo_rd = inst_q.ofifo_rd | rd;
  end

  assign bus.inst = inst_o;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      k      <= '0;
      o      <= '0;
      t      <= '0;
      nij    <= '0;
      tiles  <= '0;
      w_row  <= '0;
      x_base <= '0;
      p_base <= '0;
      acc_en <= 1'b0;
      inst_q <= IDLE_WORD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      inst_q <= inst_d;
      busy_q <= (state != IDLE);
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            w_row  <= bus.cfg_w_base;
            x_base <= bus.cfg_x_base;
            p_base <= bus.cfg_p_base;
            nij    <= bus.cfg_nij;
            tiles  <= bus.cfg_tiles;
            acc_en <= bus.cfg_acc;
            t      <= '0;
            k      <= '0;
            o      <= '0;
            state  <= (bus.cfg_nij == '0 || bus.cfg_tiles == '0) ? DONE : WL0;
          end
        end
        WL0: begin
          if (k == COL_K) begin
            k     <= '0;
            state <= WLOAD;
          end else begin
            k <= k + 1'b1;
          end
        end
        WLOAD: begin
          if (k == COL_LAST) begin
            k     <= '0;
            state <= WGAP;
          end else begin
            k <= k + 1'b1;
          end
        end
        WGAP: begin
          if (k == GAP_LAST) begin
            k     <= '0;
            state <= XL0;
          end else begin
            k <= k + 1'b1;
          end
        end
        XL0: begin
          if (k == nij) begin
            k     <= '0;
            state <= EXEC;
          end else begin
            k <= k + 1'b1;
          end
        end
        EXEC: begin
          if (k == nij - 1'b1) begin
            k     <= '0;
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          o <= '0;
          if (bus.ofifo_valid) state <= OREAD;
        end
        OREAD: begin
          // o reaches nij on the last read; its pmem write is on inst this cycle.
          if (o == nij) state <= NEXT;
          else if (rd) o <= o + 1'b1;
        end
        NEXT: begin
          t     <= t + 1'b1;
          w_row <= w_row + COL_A;
          o     <= '0;
          state <= (t + tile_w'(1) == tiles) ? DONE : WL0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: traces inst each cycle and compares against hand-derived layer sequences.
module tb_core_ctrl;
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  logic clk;
  logic reset;

  core_ctrl_if bus ();
  core_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  int xr_a[$], xr_c[$], pw_a[$], pw_acc[$], pw_c[$];
  int n_l0wr, lag_err, n_load, last_load_c, n_exec, n_rd, n_done, done_c;
  int n_both, n_bad, post_busy, busy_at_done, gap_rd, gap_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1;
    return q[i];
  endfunction

  // Starts one layer and records every cycle of inst until three cycles past done.
  task automatic run_layer(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                           input logic [10:0] nij, input logic [3:0] tiles, input logic acc,
                           input int stall_after, input int inj_cyc, input int max_c);
    logic [33:0] w;
    logic        rdx, wrp, prev_read, next_valid;
    int          gap_left;
    xr_a.delete(); xr_c.delete(); pw_a.delete(); pw_acc.delete(); pw_c.delete();
    n_l0wr = 0; lag_err = 0; n_load = 0; last_load_c = -1; n_exec = 0; n_rd = 0;
    n_done = 0; done_c = -1; n_both = 0; n_bad = 0; post_busy = 0; busy_at_done = -1;
    gap_rd = 0; gap_wr = 0; gap_left = 0; prev_read = 1'b0; next_valid = 1'b1;
    @(negedge clk);
    bus.cfg_w_base = wb; bus.cfg_x_base = xb; bus.cfg_p_base = pb;
    bus.cfg_nij = nij; bus.cfg_tiles = tiles; bus.cfg_acc = acc;
    bus.ofifo_valid = 1'b1;
    bus.start = 1'b1;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.ofifo_valid = next_valid;
      if (inj_cyc > 0 && c == inj_cyc) begin
        bus.start = 1'b1;
        bus.cfg_w_base = 11'h000; bus.cfg_x_base = 11'h010; bus.cfg_p_base = 11'h060;
        bus.cfg_nij = 11'd3; bus.cfg_tiles = 4'd2; bus.cfg_acc = 1'b1;
      end
      #1;
      w   = bus.inst;
      rdx = !w[19];
      wrp = !w[32];
      if (rdx) begin xr_a.push_back(int'(w[17:7])); xr_c.push_back(c); end
      if (wrp) begin pw_a.push_back(int'(w[30:20])); pw_acc.push_back(int'(w[33])); pw_c.push_back(c); end
      if (w[2]) begin n_l0wr++; if (!prev_read) lag_err++; end
      prev_read = rdx;
      if (w[0]) begin n_load++; last_load_c = c; end
      if (w[1]) n_exec++;
      if (w[6]) n_rd++;
      if (rdx && wrp) n_both++;
      if ((rdx && !w[18]) || (wrp && w[31]) || w[5] || w[4]) n_bad++;
      if (bus.done) begin
        n_done++;
        if (n_done == 1) begin done_c = c; busy_at_done = int'(bus.busy); end
      end else if (n_done > 0 && bus.busy) begin
        post_busy++;
      end
      if (gap_left > 0) begin
        if (w[6]) gap_rd++;
        if (wrp && gap_left <= 2) gap_wr++;
        gap_left--;
        if (gap_left == 0) next_valid = 1'b1;
      end
      if (stall_after > 0 && w[6] && n_rd == stall_after) begin
        next_valid = 1'b0;
        gap_left = 3;
      end
      if (n_done > 0 && c >= done_c + 3) break;
    end
  endtask

  initial begin
    logic seen;
    int   exp_wrap[8];
    exp_wrap = '{11'h7FC, 11'h7FD, 11'h7FE, 11'h7FF, 11'h000, 11'h001, 11'h002, 11'h003};
    reset = 1'b0;
    bus.start = 1'b0; bus.cfg_w_base = '0; bus.cfg_x_base = '0; bus.cfg_p_base = '0;
    bus.cfg_nij = '0; bus.cfg_tiles = '0; bus.cfg_acc = 1'b0; bus.ofifo_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_inst", bus.inst, IDLE_WORD);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Async reset in the middle of EXEC
    bus.cfg_w_base = 11'h010; bus.cfg_x_base = 11'h100; bus.cfg_p_base = 11'h200;
    bus.cfg_nij = 11'd4; bus.cfg_tiles = 4'd1; bus.cfg_acc = 1'b0; bus.ofifo_valid = 1'b1;
    bus.start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.inst[1]) begin seen = 1'b1; break; end
    end
    chk("rst_exec_reached", seen, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_async_inst", bus.inst, IDLE_WORD);
    chk("rst_async_busy", bus.busy, 1'b0);
    chk("rst_async_done", bus.done, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_after_inst", bus.inst, IDLE_WORD);
    chk("rst_after_busy", bus.busy, 1'b0);

    // Basic single tile, nij=4
    run_layer(11'h010, 11'h100, 11'h200, 11'd4, 4'd1, 1'b0, 0, 0, 300);
    chk("t2_nreads", xr_a.size(), 12);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_wrd%0d", i), qget(xr_a, i), 'h10 + i);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_xrd%0d", i), qget(xr_a, 8 + i), 'h100 + i);
    chk("t2_first_read_cyc", qget(xr_c, 0), 2);
    chk("t2_l0wr_count", n_l0wr, 12);
    chk("t2_l0wr_lag", lag_err, 0);
    chk("t2_loads", n_load, 8);
    chk("t2_flush_gap", qget(xr_c, 8) - last_load_c, 9);
    chk("t2_execs", n_exec, 4);
    chk("t2_ofifo_rds", n_rd, 4);
    chk("t2_nwrites", pw_a.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_pwa%0d", i), qget(pw_a, i), 'h200 + i);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_pacc%0d", i), qget(pw_acc, i), 0);
    chk("t2_done_count", n_done, 1);
    chk("t2_done_lat", done_c - qget(pw_c, 3), 3);
    chk("t2_busy_at_done", busy_at_done, 1);
    chk("t2_busy_after", post_busy, 0);
    chk("t2_both", n_both, 0);
    chk("t2_bad_bits", n_bad, 0);

    // Three accumulating tiles
    run_layer(11'h020, 11'h100, 11'h080, 11'd2, 4'd3, 1'b1, 0, 0, 600);
    chk("t3_nreads", xr_a.size(), 30);
    chk("t3_tile0_w", qget(xr_a, 0), 'h20);
    chk("t3_tile1_w", qget(xr_a, 10), 'h28);
    chk("t3_tile2_w", qget(xr_a, 20), 'h30);
    chk("t3_loads", n_load, 24);
    chk("t3_nwrites", pw_a.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_pwa%0d", i), qget(pw_a, i), 'h80 + (i % 2));
    for (int i = 0; i < 6; i++) chk($sformatf("t3_pacc%0d", i), qget(pw_acc, i), (i >= 2) ? 1 : 0);
    chk("t3_done_count", n_done, 1);
    chk("t3_both", n_both, 0);

    // OFIFO stall after second output
    run_layer(11'h010, 11'h100, 11'h200, 11'd4, 4'd1, 1'b0, 2, 0, 300);
    chk("t4_ofifo_rds", n_rd, 4);
    chk("t4_gap_rd", gap_rd, 0);
    chk("t4_gap_wr", gap_wr, 0);
    chk("t4_nwrites", pw_a.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_pwa%0d", i), qget(pw_a, i), 'h200 + i);
    chk("t4_resume_gap", qget(pw_c, 2) - qget(pw_c, 1), 4);
    chk("t4_done_count", n_done, 1);

    // Empty layers
    run_layer(11'h010, 11'h100, 11'h200, 11'd0, 4'd1, 1'b0, 0, 0, 50);
    chk("t5_nij0_done_cyc", done_c, 2);
    chk("t5_nij0_reads", xr_a.size(), 0);
    chk("t5_nij0_writes", pw_a.size(), 0);
    run_layer(11'h010, 11'h100, 11'h200, 11'd3, 4'd0, 1'b0, 0, 0, 50);
    chk("t5_tiles0_done_cyc", done_c, 2);
    chk("t5_tiles0_reads", xr_a.size(), 0);

    // xmem address wrap
    run_layer(11'h7FC, 11'h100, 11'h200, 11'd1, 4'd1, 1'b0, 0, 0, 200);
    chk("t5_wrap_nreads", xr_a.size(), 9);
    for (int i = 0; i < 8; i++) chk($sformatf("t5_wrap%0d", i), qget(xr_a, i), exp_wrap[i]);

    // start while busy is ignored
    run_layer(11'h040, 11'h300, 11'h050, 11'd2, 4'd1, 1'b0, 0, 5, 300);
    chk("t6_nreads", xr_a.size(), 10);
    chk("t6_first_w", qget(xr_a, 0), 'h40);
    chk("t6_x0", qget(xr_a, 8), 'h300);
    chk("t6_x1", qget(xr_a, 9), 'h301);
    chk("t6_nwrites", pw_a.size(), 2);
    chk("t6_pw0", qget(pw_a, 0), 'h50);
    chk("t6_pw1", qget(pw_a, 1), 'h51);
    chk("t6_done_count", n_done, 1);
    chk("t6_busy_after", post_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
